// File: rtl/enokida_mem_port_arbiter.sv
// Two-port arbiter for the shared RI5CY-protocol data memory port: cache traffic on port 0,
// uncached LSU bypass on port 1, with address-phase hold and in-order response routing.
module enokida_mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   fixed_prio_i,

    input  logic                                   p0_req_i,
    input  logic [ADDR_WIDTH-1:0]                  p0_addr_i,
    input  logic                                   p0_we_i,
    input  logic [DATA_WIDTH/8-1:0]                p0_be_i,
    input  logic [DATA_WIDTH-1:0]                  p0_wdata_i,
    output logic                                   p0_gnt_o,
    output logic                                   p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  p0_rdata_o,

    input  logic                                   p1_req_i,
    input  logic [ADDR_WIDTH-1:0]                  p1_addr_i,
    input  logic                                   p1_we_i,
    input  logic [DATA_WIDTH/8-1:0]                p1_be_i,
    input  logic [DATA_WIDTH-1:0]                  p1_wdata_i,
    output logic                                   p1_gnt_o,
    output logic                                   p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  p1_rdata_o,

    output logic                                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic [31:0]                            gnt_count0_o,
    output logic [31:0]                            gnt_count1_o,
    output logic                                   err_o
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   owner;
    logic                   owner_nxt;
    logic                   sel;
    logic                   last_grant;
    logic                   grant;
    logic                   resp;
    logic                   head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_WIDTH-1:0]   count;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic                   tags [MAX_OUTSTANDING];

    // Full/empty come from the registered count so a same-cycle response never unblocks issue.
    assign fifo_full  = (count == CNT_MAX);
    assign fifo_empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Winner selection, address-phase hold and memory request generation.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        sel       = 1'b0;
        mem_req_o = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!fifo_full) begin
                        if (p0_req_i && p1_req_i) begin
                            sel = fixed_prio_i ? 1'b0 : ~last_grant;
                        end else begin
                            sel = p1_req_i;
                        end
                        mem_req_o = p0_req_i | p1_req_i;
                        if (mem_req_o && !mem_gnt_i) begin
                            state_nxt = HOLD;
                            owner_nxt = sel;
                        end
                    end
                end
                HOLD: begin
                    sel       = owner;
                    mem_req_o = owner ? p1_req_i : p0_req_i;
                    if (mem_gnt_i) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Address phase is muxed from the selected port and zeroed when nothing is requested.
    assign mem_addr_o  = mem_req_o ? (sel ? p1_addr_i  : p0_addr_i)  : '0;
    assign mem_we_o    = mem_req_o & (sel ? p1_we_i : p0_we_i);
    assign mem_be_o    = mem_req_o ? (sel ? p1_be_i    : p0_be_i)    : BE_WIDTH'(0);
    assign mem_wdata_o = mem_req_o ? (sel ? p1_wdata_i : p0_wdata_i) : '0;

    assign grant    = mem_gnt_i & mem_req_o;
    assign p0_gnt_o = grant & ~sel;
    assign p1_gnt_o = grant & sel;

    assign head        = tags[rd_ptr];
    assign resp        = mem_rvalid_i & ~fifo_empty & ~rst;
    assign p0_rvalid_o = resp & ~head;
    assign p1_rvalid_o = resp & head;
    assign p0_rdata_o  = mem_rdata_i;
    assign p1_rdata_o  = mem_rdata_i;

    always_ff @(posedge clk) begin
        if (grant) begin
            tags[wr_ptr] <= sel;
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap at MAX_OUTSTANDING, not at a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_WIDTH'(1);
            end
            if (resp) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_WIDTH'(1);
            end
            case ({grant, resp})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            gnt_count0_o <= '0;
            gnt_count1_o <= '0;
            err_o        <= 1'b0;
        end else begin
            if (grant) begin
                last_grant <= sel;
            end
            if (p0_gnt_o) begin
                gnt_count0_o <= gnt_count0_o + 32'd1;
            end
            if (p1_gnt_o) begin
                gnt_count1_o <= gnt_count1_o + 32'd1;
            end
            if (mem_rvalid_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    assign outstanding_o = count;

endmodule

// File: tb/tb_enokida_mem_port_arbiter.sv
// Table-driven bench for enokida_mem_port_arbiter; a tag queue predicts response routing.
module tb_enokida_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 2;
    localparam int unsigned CW = $clog2(MO + 1);

    localparam logic [AW-1:0]   P0_ADDR = 16'h1000;
    localparam logic [AW-1:0]   P1_ADDR = 16'h0040;
    localparam logic [DW/8-1:0] P0_BE   = 4'hF;
    localparam logic [DW/8-1:0] P1_BE   = 4'hC;
    localparam logic [DW-1:0]   P0_WD   = 32'hA5A5A5A5;
    localparam logic [DW-1:0]   P1_WD   = 32'h12345678;

    logic            clk;
    logic            rst;
    logic            fixed_prio;
    logic            p0_req, p1_req;
    logic            p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0]   p0_rdata, p1_rdata;
    logic            mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0]   mem_addr;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [CW-1:0]   outstanding;
    logic [31:0]     gnt_count0, gnt_count1;
    logic            err;

    enokida_mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .fixed_prio_i(fixed_prio),
        .p0_req_i(p0_req), .p0_addr_i(P0_ADDR), .p0_we_i(1'b0), .p0_be_i(P0_BE),
        .p0_wdata_i(P0_WD), .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_addr_i(P1_ADDR), .p1_we_i(1'b1), .p1_be_i(P1_BE),
        .p1_wdata_i(P1_WD), .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .outstanding_o(outstanding),
        .gnt_count0_o(gnt_count0), .gnt_count1_o(gnt_count1), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst, fix, r0, r1, gnt, rv;
        logic ereq, src, g0, g1;
    } vec_t;

    int          n_vec;
    int          n_err;
    int          q[$];
    logic [31:0] c0_m, c1_m;
    logic        err_m;
    logic        first_rdata;
    vec_t        vecs[$];

    function automatic vec_t mk(logic rs, logic fx, logic a, logic b, logic g, logic rv,
                                logic er, logic sr, logic e0, logic e1);
        vec_t v;
        v.rst = rs; v.fix = fx; v.r0 = a; v.r1 = b; v.gnt = g; v.rv = rv;
        v.ereq = er; v.src = sr; v.g0 = e0; v.g1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle, check the zero-latency outputs, then the registered state after the edge.
    task automatic apply(input vec_t v);
        int   t;
        logic e0, e1;
        rst        = v.rst;
        fixed_prio = v.fix;
        p0_req     = v.r0;
        p1_req     = v.r1;
        mem_gnt    = v.gnt;
        mem_rvalid = v.rv;
        mem_rdata  = (v.rv && first_rdata) ? 32'hDEADBEEF : $urandom;
        if (v.rv) first_rdata = 1'b0;
        #2;
        check("mem_req", 32'(mem_req), 32'(v.ereq));
        if (v.ereq) begin
            check("mem_addr",  32'(mem_addr),  v.src ? 32'(P1_ADDR) : 32'(P0_ADDR));
            check("mem_we",    32'(mem_we),    32'(v.src));
            check("mem_be",    32'(mem_be),    v.src ? 32'(P1_BE) : 32'(P0_BE));
            check("mem_wdata", mem_wdata,      v.src ? P1_WD : P0_WD);
        end
        check("p0_gnt", 32'(p0_gnt), 32'(v.g0));
        check("p1_gnt", 32'(p1_gnt), 32'(v.g1));
        e0 = 1'b0;
        e1 = 1'b0;
        if (!v.rst && v.rv) begin
            if (q.size() > 0) begin
                t  = q.pop_front();
                e0 = (t == 0);
                e1 = (t == 1);
                check(e0 ? "p0_rdata" : "p1_rdata", e0 ? p0_rdata : p1_rdata, mem_rdata);
            end else begin
                err_m = 1'b1;
            end
        end
        check("p0_rvalid", 32'(p0_rvalid), 32'(e0));
        check("p1_rvalid", 32'(p1_rvalid), 32'(e1));
        if (v.rst) begin
            q.delete();
            c0_m  = '0;
            c1_m  = '0;
            err_m = 1'b0;
        end else begin
            if (v.g0) begin q.push_back(0); c0_m++; end
            if (v.g1) begin q.push_back(1); c1_m++; end
        end
        @(posedge clk);
        #1;
        check("outstanding", 32'(outstanding), 32'(q.size()));
        check("gnt_count0",  gnt_count0, c0_m);
        check("gnt_count1",  gnt_count1, c1_m);
        check("err",         32'(err),   32'(err_m));
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        c0_m = '0; c1_m = '0; err_m = 1'b0; first_rdata = 1'b1;
        rst = 1'b1; fixed_prio = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        //            rst fix r0 r1 gnt rv  ereq src g0 g1
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        // single p0 read, response next cycle
        vecs.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0));
        // round robin then fixed priority
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,  1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,  1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 0));
        // p1 held three cycles; p0 and fixed priority ignored meanwhile
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0,  1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0,  1, 0, 1, 0));
        // full: issue blocked, including the cycle a response arrives
        vecs.push_back(mk(0, 1, 1, 0, 1, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 0));
        // grants p0,p1,p0 with in-order responses, then a stray response
        vecs.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        // reset with two outstanding, late response afterwards
        vecs.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Owner drops its request mid-hold: mem_req follows it and the hold survives.
        apply(mk(0, 1, 1, 1, 0, 0,  1, 0, 0, 0));
        apply(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0));
        apply(mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 0));
        apply(mk(0, 0, 1, 1, 1, 0,  1, 0, 1, 0));
        apply(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 1));
        apply(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
